imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Sequences the combinational, byte-addressed instruction memory. Owns the PC and presents fetched instructions to decode through a registered valid/ready slot. Applies branch/jump redirects from execute. Shares the memory port with a boot loader that writes program words before the core runs.

Parameters:
INS_ADDRESS, 32, PC / memory address width
INS_W, 32, instruction width
RESET_PC, 0, PC loaded on reset and on every start
PC_STEP, 4, PC increment per fetched instruction (memory entries sit at byte addresses 0,4,8,…)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
imem_addr  out  INS_ADDRESS  memory address (PC in RUN, load_addr in LOAD)
imem_rdata  in  INS_W  memory read data, same-cycle combinational
imem_we  out  1  loader write strobe to memory
imem_wdata  out  INS_W  loader write data
load_valid  in  1  loader has a word
load_ready  out  1  controller accepts loader word
load_addr  in  INS_ADDRESS  loader target byte address
load_data  in  INS_W  loader word
start  in  1  pulse: begin execution from RESET_PC
halt_req  in  1  level: stop fetching
redirect_valid  in  1  taken branch/jal/jalr this cycle
redirect_pc  in  INS_ADDRESS  redirect target
if_valid  out  1  fetch slot holds an instruction
if_ready  in  1  decode consumes the slot
if_pc  out  INS_ADDRESS  PC of slot instruction
if_instr  out  INS_W  slot instruction
state_o  out  2  current state (debug)

Behaviour:
- States: LOAD=0, RUN=1, HALT=2. Encodings live in the package.
- Reset values: state=LOAD, pc=RESET_PC, if_valid=0, if_pc=0, if_instr=0, imem_we=0, imem_wdata=0, load_ready=0.
- LOAD:
  - load_ready=1; imem_addr=load_addr; imem_we=load_valid; imem_wdata=load_data. All combinational.
  - No fetch; if_valid=0.
  - start → RUN, pc=RESET_PC.
  - start together with load_valid: the write completes this cycle, then the state moves to RUN.
- RUN:
  - load_ready=0; imem_we=0; imem_addr=pc.
  - Slot "free" = !if_valid || if_ready.
  - If free and no redirect: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+PC_STEP. One-cycle latency from pc to slot.
  - If not free: pc and slot hold (stall). if_instr and if_pc must stay stable while if_valid && !if_ready.
  - Redirect has highest priority: pc<={redirect_pc[INS_ADDRESS-1:2],2'b00}, if_valid<=0, no capture that cycle. This holds regardless of if_ready or halt_req.
  - halt_req=1 with no redirect → HALT. A slot already valid is kept until consumed; no new capture.
  - PC wraps modulo 2^INS_ADDRESS; no error.
- HALT:
  - No capture. The slot drains normally through if_ready.
  - Redirect updates pc and flushes the slot.
  - halt_req=0 → RUN, resuming at the held pc.
  - start → RUN with pc=RESET_PC and the slot flushed.
- start in RUN restarts: pc=RESET_PC, if_valid<=0.
- Loader inputs are ignored outside LOAD (load_ready=0).
- Asynchronous reset mid-operation returns everything to reset values immediately, including a flushed slot.

Optional Feature:
- Macro: IMEM_FETCH_ZERO_HALT_EN.
- When defined: in RUN, a captured imem_rdata == 0 (uninitialised word) is still placed in the slot. The controller then enters HALT on the following edge with pc held at the zero word's address+PC_STEP. halt_req=0 does not resume from this state; only start does. This halt is tracked with a sticky zero_halt flag, cleared by start or reset.
- When undefined: zero words are fetched like any instruction and there is no zero_halt flag.

Decomposition:
- Package imem_fetch_pkg: state enum fetch_state_e (LOAD/RUN/HALT), PC_STEP default, and an alignment mask constant.
- One sub-module, fetch_slot: a registered valid/ready holding stage with flush input, reused later for decode.
- The PC/FSM logic stays in the top module.

Test Plan:
- Load, then run: load words at 0x0, 0x4, 0x8, then start, with if_ready=1 → if_pc 0x0, 0x4, 0x8 on consecutive cycles, carrying the loaded instructions; first if_valid one cycle after start.
- Decode stall: hold if_ready=0 for 3 cycles with a slot at pc=0x4 → if_pc/if_instr stay stable; pc stays 0x8; release gives pc 0x8 next.
- Redirect flush: redirect_valid with redirect_pc=0x17 while the slot is valid and stalled → if_valid=0 next cycle; the next fetch has if_pc=0x14.
- Simultaneous events: redirect together with halt_req=1 → the redirect is applied and the state is HALT. Deassert halt_req → the first fetch is at the redirect target.
- Reset mid-RUN: assert rst_n=0 asynchronously with if_valid=1 → if_valid=0 and state=LOAD without waiting for a clock edge; load_ready=1 after release.
- With IMEM_FETCH_ZERO_HALT_EN: a zero word at 0xC → the slot delivers 0x00000000 at if_pc=0xC, the state is HALT, and halt_req toggling does not resume; start restarts at 0x0.

Source files
------------

// File: rtl/imem_fetch_pkg.sv
// rtl/imem_fetch_pkg.sv - state encoding and address constants for the instruction fetch controller
package imem_fetch_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_STEP_DEF = 4;

  // Low address bits forced to zero on a redirect target.
  localparam int unsigned ALIGN_LSB_MASK = 3;

endpackage

// File: rtl/imem_fetch_ctrl_fetch_slot.sv
// rtl/imem_fetch_ctrl_fetch_slot.sv - registered valid/ready holding stage with flush
module fetch_slot #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [PC_W-1:0]   o_pc,
  output logic [DATA_W-1:0] o_data,
  output logic              o_free
);

  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_data;

  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_data  = r_data;

  // Flush wins over load so a redirect never lets a stale word through.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - PC sequencing, boot-load arbitration and fetch slot for the instruction memory
// Optional: IMEM_FETCH_ZERO_HALT_EN stops fetching after an all-zero instruction until the next start.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter int                     INS_ADDRESS = 32,
  parameter int                     INS_W       = 32,
  parameter logic [INS_ADDRESS-1:0] RESET_PC    = '0,
  parameter int unsigned            PC_STEP     = PC_STEP_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  output logic [INS_ADDRESS-1:0] o_imem_addr,
  input  logic [INS_W-1:0]       i_imem_rdata,
  output logic                   o_imem_we,
  output logic [INS_W-1:0]       o_imem_wdata,
  input  logic                   i_load_valid,
  output logic                   o_load_ready,
  input  logic [INS_ADDRESS-1:0] i_load_addr,
  input  logic [INS_W-1:0]       i_load_data,
  input  logic                   i_start,
  input  logic                   i_halt_req,
  input  logic                   i_redirect_valid,
  input  logic [INS_ADDRESS-1:0] i_redirect_pc,
  output logic                   o_if_valid,
  input  logic                   i_if_ready,
  output logic [INS_ADDRESS-1:0] o_if_pc,
  output logic [INS_W-1:0]       o_if_instr,
  output logic [1:0]             o_state
);

  localparam logic [INS_ADDRESS-1:0] ALIGN_MASK = ~INS_ADDRESS'(ALIGN_LSB_MASK);
  localparam logic [INS_ADDRESS-1:0] STEP       = INS_ADDRESS'(PC_STEP);

  fetch_state_e           r_state;
  fetch_state_e           w_state_nxt;
  logic [INS_ADDRESS-1:0] r_pc;
  logic [INS_ADDRESS-1:0] w_pc_nxt;
  logic                   w_capture;
  logic                   w_flush;
  logic                   w_free;

`ifdef IMEM_FETCH_ZERO_HALT_EN
  logic r_zero_halt;
  logic w_zero_halt_nxt;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_capture    = 1'b0;
    w_flush      = 1'b0;
    o_imem_addr  = r_pc;
    o_imem_we    = 1'b0;
    o_imem_wdata = '0;
    o_load_ready = 1'b0;
`ifdef IMEM_FETCH_ZERO_HALT_EN
    w_zero_halt_nxt = r_zero_halt;
`endif
    case (r_state)
      ST_LOAD: begin
        // Loader outputs are gated by reset so they read idle while rst_n is low.
        o_load_ready = i_rst_n;
        o_imem_addr  = i_load_addr;
        o_imem_we    = i_load_valid && i_rst_n;
        o_imem_wdata = i_rst_n ? i_load_data : '0;
        w_flush      = 1'b1;
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = RESET_PC;
        end
      end
      ST_RUN: begin
        if (i_start) begin
          w_pc_nxt = RESET_PC;
          w_flush  = 1'b1;
`ifdef IMEM_FETCH_ZERO_HALT_EN
          w_zero_halt_nxt = 1'b0;
`endif
        end else begin
          if (i_redirect_valid) begin
            w_pc_nxt = i_redirect_pc & ALIGN_MASK;
            w_flush  = 1'b1;
          end else if (!i_halt_req && w_free) begin
            w_capture = 1'b1;
            w_pc_nxt  = r_pc + STEP;
`ifdef IMEM_FETCH_ZERO_HALT_EN
            if (i_imem_rdata == '0) begin
              w_state_nxt     = ST_HALT;
              w_zero_halt_nxt = 1'b1;
            end
`endif
          end
          if (i_halt_req) begin
            w_state_nxt = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = RESET_PC;
          w_flush     = 1'b1;
`ifdef IMEM_FETCH_ZERO_HALT_EN
          w_zero_halt_nxt = 1'b0;
`endif
        end else begin
          if (i_redirect_valid) begin
            w_pc_nxt = i_redirect_pc & ALIGN_MASK;
            w_flush  = 1'b1;
          end
`ifdef IMEM_FETCH_ZERO_HALT_EN
          if (!i_halt_req && !r_zero_halt) begin
            w_state_nxt = ST_RUN;
          end
`else
          if (!i_halt_req) begin
            w_state_nxt = ST_RUN;
          end
`endif
        end
      end
      default: begin
        w_state_nxt = ST_LOAD;
        w_flush     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_LOAD;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

`ifdef IMEM_FETCH_ZERO_HALT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_zero_halt <= 1'b0;
    end else begin
      r_zero_halt <= w_zero_halt_nxt;
    end
  end
`endif

  fetch_slot #(
    .PC_W   (INS_ADDRESS),
    .DATA_W (INS_W)
  ) u_slot (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (w_flush),
    .i_load  (w_capture),
    .i_pc    (r_pc),
    .i_data  (i_imem_rdata),
    .i_ready (i_if_ready),
    .o_valid (o_if_valid),
    .o_pc    (o_if_pc),
    .o_data  (o_if_instr),
    .o_free  (w_free)
  );

  assign o_state = r_state;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - scoreboard bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        start;
  logic        halt_req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [1:0]  state_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests;
  int          n_fail;
  logic [31:0] mem [0:63];
  logic [31:0] words [0:6];

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[7:2]];

  always @(posedge clk) begin
    if (imem_we) mem[imem_addr[7:2]] <= imem_wdata;
  end

  imem_fetch_ctrl dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .o_imem_addr      (imem_addr),
    .i_imem_rdata     (imem_rdata),
    .o_imem_we        (imem_we),
    .o_imem_wdata     (imem_wdata),
    .i_load_valid     (load_valid),
    .o_load_ready     (load_ready),
    .i_load_addr      (load_addr),
    .i_load_data      (load_data),
    .i_start          (start),
    .i_halt_req       (halt_req),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_if_valid       (if_valid),
    .i_if_ready       (if_ready),
    .o_if_pc          (if_pc),
    .o_if_instr       (if_instr),
    .o_state          (state_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake on the fetch slot must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && if_valid === 1'b1 && if_ready === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_fetch: got pc %h instr %h expected none", if_pc, if_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          n_fail++;
          $display("FAIL fetch_stream: got pc %h instr %h expected pc %h instr %h",
                   if_pc, if_instr, e.pc, e.instr);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    words = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213,
              32'h0050_0293, 32'h0060_0313, 32'h0070_0393};
    rst_n = 1'b1; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    if_ready = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    #9 rst_n = 1'b1;
    tick();
    check("load_ready_after_rst", 32'(load_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1;
      load_addr  = 32'(i * 4);
      load_data  = words[i];
      #1;
      check("load_we", 32'(imem_we), 32'd1);
      check("load_addr_mux", imem_addr, 32'(i * 4));
      tick();
    end

    // Last word written in the same cycle as start.
    load_valid = 1'b1; load_addr = 32'h18; load_data = words[6]; start = 1'b1;
    tick();
    load_valid = 1'b0; start = 1'b0; if_ready = 1'b1;
    push_exp(32'h0, words[0]);
    push_exp(32'h4, words[1]);
    check("start_state_run", 32'(state_o), 32'd1);
    check("start_if_valid_low", 32'(if_valid), 32'd0);
    check("start_load_ready_low", 32'(load_ready), 32'd0);
    check("start_with_load_written", mem[6], words[6]);
    tick();
    check("first_fetch_valid", 32'(if_valid), 32'd1);
    check("first_fetch_pc", if_pc, 32'h0);
    tick();
    if_ready = 1'b0;
    check("second_fetch_pc", if_pc, 32'h4);

    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", if_pc, 32'h4);
      check("stall_instr", if_instr, words[1]);
      check("stall_imem_addr", imem_addr, 32'h8);
    end
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    check("release_pc", if_pc, 32'h8);
    check("release_instr", if_instr, words[2]);

    redirect_valid = 1'b1; redirect_pc = 32'h17;
    tick();
    redirect_valid = 1'b0;
    check("redirect_flush", 32'(if_valid), 32'd0);
    check("redirect_aligned_pc", imem_addr, 32'h14);
    tick();
    check("redirect_fetch_valid", 32'(if_valid), 32'd1);
    check("redirect_fetch_pc", if_pc, 32'h14);
    check("redirect_fetch_instr", if_instr, words[5]);

    redirect_valid = 1'b1; redirect_pc = 32'h4; halt_req = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("redir_halt_state", 32'(state_o), 32'd2);
    check("redir_halt_flush", 32'(if_valid), 32'd0);
    check("redir_halt_pc", imem_addr, 32'h4);
    repeat (2) tick();
    check("halt_hold_state", 32'(state_o), 32'd2);
    check("halt_no_capture", 32'(if_valid), 32'd0);

    push_exp(32'h4, words[1]);
    push_exp(32'h8, words[2]);
    if_ready = 1'b1; halt_req = 1'b0;
    tick();
    check("resume_state", 32'(state_o), 32'd1);
    check("resume_no_slot_yet", 32'(if_valid), 32'd0);
    tick();
    check("resume_first_pc", if_pc, 32'h4);
    tick();
    halt_req = 1'b1;
    tick();
    check("rehalt_state", 32'(state_o), 32'd2);
    check("rehalt_drained", 32'(if_valid), 32'd0);
    check("rehalt_pc", imem_addr, 32'hC);

    halt_req = 1'b0; if_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_state", 32'(state_o), 32'd1);
    tick();
    check("pre_reset_valid", 32'(if_valid), 32'd1);
    check("pre_reset_pc", if_pc, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_if_valid", 32'(if_valid), 32'd0);
    check("async_rst_state", 32'(state_o), 32'd0);
    check("async_rst_load_ready", 32'(load_ready), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_load_ready", 32'(load_ready), 32'd1);
    check("post_rst_state", 32'(state_o), 32'd0);

`ifdef IMEM_FETCH_ZERO_HALT_EN
    load_valid = 1'b1; load_addr = 32'hC; load_data = 32'h0;
    tick();
    load_valid = 1'b0; if_ready = 1'b1;
    push_exp(32'h0, words[0]);
    push_exp(32'h4, words[1]);
    push_exp(32'h8, words[2]);
    push_exp(32'hC, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("zero_halt_state", 32'(state_o), 32'd2);
    check("zero_halt_slot_pc", if_pc, 32'hC);
    check("zero_halt_slot_instr", if_instr, 32'h0);
    check("zero_halt_pc", imem_addr, 32'h10);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    repeat (2) tick();
    check("zero_halt_sticky", 32'(state_o), 32'd2);
    check("zero_halt_no_fetch", 32'(if_valid), 32'd0);
    push_exp(32'h0, words[0]);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_halt_restart", 32'(state_o), 32'd1);
    tick();
    halt_req = 1'b1;
    check("zero_halt_restart_pc", if_pc, 32'h0);
    tick();
    check("zero_halt_rehalt", 32'(state_o), 32'd2);
`endif

    repeat (2) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
